// File: rtl/rv32i_decode_stage_if.sv
// Handshake bundles around the RV32I decode stage:
// fetch-to-decode request and decode-to-execute result.
interface rv32i_decode_stage_in_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] pc;

   modport master (
      output in_valid, instr, pc,
      input  in_ready
   );
   modport slave (
      input  in_valid, instr, pc,
      output in_ready
   );
endinterface

interface rv32i_decode_stage_out_if #(
   parameter int XLEN = 32
);
   logic            out_valid;
   logic            out_ready;
   logic [6:0]      Opcode;
   logic [3:0]      FuncCode;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] pc_out;
   logic            illegal;

   modport master (
      output out_valid, Opcode, FuncCode, rd, rs1, rs2,
      output imm, pc_out, illegal,
      input  out_ready
   );
   modport slave (
      input  out_valid, Opcode, FuncCode, rd, rs1, rs2,
      input  imm, pc_out, illegal,
      output out_ready
   );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational decode into a two-entry
// skid buffer (output register + skid register).
module rv32i_decode_stage #(
   parameter int XLEN         = 32,
   parameter bit ILLEGAL_PASS = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   rv32i_decode_stage_in_if.slave   fe,
   rv32i_decode_stage_out_if.master ex
);

   typedef struct packed {
      logic [6:0]      opcode;
      logic [3:0]      func_code;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } dec_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic [XLEN-1:0] ins;
   logic [6:0]      op;
   logic [2:0]      f3;
   logic            t_r, t_i, t_s, t_b, t_u, t_j;
   dec_t            dec;

   assign ins = fe.instr;
   assign op  = ins[6:0];
   assign f3  = ins[14:12];

   assign t_r = (op == OP_R);
   assign t_i = (op == OP_IMM) | (op == OP_LD) | (op == OP_JLR);
   assign t_s = (op == OP_ST);
   assign t_b = (op == OP_BR);
   assign t_u = (op == OP_LUI) | (op == OP_AUI);
   assign t_j = (op == OP_JAL);

   always_comb begin
      dec           = '0;
      dec.opcode    = op;
      dec.pc        = fe.pc;
      dec.func_code = {1'b0, f3};
      // alt bit only distinguishes sub/sra/srai; elsewhere it is immediate data
      if (t_r || (op == OP_IMM && f3 == 3'b101))
         dec.func_code[3] = ins[30];
      dec.rd  = (t_s || t_b) ? 5'd0 : ins[11:7];
      dec.rs1 = (t_u || t_j) ? 5'd0 : ins[19:15];
      dec.rs2 = (t_r || t_s || t_b) ? ins[24:20] : 5'd0;
      dec.illegal = ~(t_r | t_i | t_s | t_b | t_u | t_j);
      unique case (1'b1)
         t_i: dec.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
         t_s: dec.imm = {{(XLEN-12){ins[31]}}, ins[31:25],
                         ins[11:7]};
         t_b: dec.imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
         t_u: dec.imm = {ins[31:12], 12'b0};
         t_j: dec.imm = {{(XLEN-21){ins[31]}}, ins[31],
                         ins[19:12], ins[20], ins[30:21], 1'b0};
         default: dec.imm = '0;
      endcase
   end

   dec_t or_q, sk_q;
   logic or_vld, sk_vld;
   logic acc, keep, out_fire, or_free;

   assign acc      = fe.in_valid & fe.in_ready;
   assign keep     = acc & (ILLEGAL_PASS | ~dec.illegal);
   assign out_fire = or_vld & ex.out_ready;
   assign or_free  = ~or_vld | out_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         or_vld <= 1'b0;
         sk_vld <= 1'b0;
         or_q   <= '0;
         sk_q   <= '0;
      end else if (flush) begin
         or_vld <= 1'b0;
         sk_vld <= 1'b0;
      end else if (or_free) begin
         if (sk_vld) begin
            // older skid entry takes the output slot first
            or_q   <= sk_q;
            or_vld <= 1'b1;
            sk_vld <= keep;
            if (keep)
               sk_q <= dec;
         end else begin
            or_vld <= keep;
            if (keep)
               or_q <= dec;
         end
      end else if (keep) begin
         sk_q   <= dec;
         sk_vld <= 1'b1;
      end
   end

   assign fe.in_ready  = ~sk_vld;
   assign ex.out_valid = or_vld;
   assign ex.Opcode    = or_q.opcode;
   assign ex.FuncCode  = or_q.func_code;
   assign ex.rd        = or_q.rd;
   assign ex.rs1       = or_q.rs1;
   assign ex.rs2       = or_q.rs2;
   assign ex.imm       = or_q.imm;
   assign ex.pc_out    = or_q.pc;
   assign ex.illegal   = or_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed cases
// plus randomized traffic against a queue-based reference model.
module tb_rv32i_decode_stage;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   typedef struct packed {
      logic [6:0]  op;
      logic [3:0]  fc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        ill;
   } dec_t;

   dec_t q[$];

   rv32i_decode_stage_in_if  #(.XLEN(32)) u_in1 ();
   rv32i_decode_stage_out_if #(.XLEN(32)) u_out1 ();
   rv32i_decode_stage_in_if  #(.XLEN(32)) u_in0 ();
   rv32i_decode_stage_out_if #(.XLEN(32)) u_out0 ();

   rv32i_decode_stage #(.XLEN(32), .ILLEGAL_PASS(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .fe    (u_in1),
      .ex    (u_out1)
   );

   rv32i_decode_stage #(.XLEN(32), .ILLEGAL_PASS(1'b0)) dut_drop (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .fe    (u_in0),
      .ex    (u_out0)
   );

   function automatic dec_t got1();
      got1 = {u_out1.Opcode, u_out1.FuncCode, u_out1.rd,
              u_out1.rs1, u_out1.rs2, u_out1.imm,
              u_out1.pc_out, u_out1.illegal};
   endfunction

   // Reference decode from the instruction-format rules
   function automatic dec_t model(logic [31:0] i, logic [31:0] p);
      dec_t d;
      byte  t;
      int   s;
      logic alt;
      s = i;
      case (i[6:0])
         7'h33:               t = "R";
         7'h13, 7'h03, 7'h67: t = "I";
         7'h23:               t = "S";
         7'h63:               t = "B";
         7'h37, 7'h17:        t = "U";
         7'h6f:               t = "J";
         default:             t = "X";
      endcase
      alt = ((i[6:0] == 7'h33) ||
             (i[6:0] == 7'h13 && i[14:12] == 3'd5)) ? i[30] : 1'b0;
      d.op  = i[6:0];
      d.fc  = {alt, i[14:12]};
      d.rd  = (t == "S" || t == "B") ? 5'd0 : i[11:7];
      d.rs1 = (t == "U" || t == "J") ? 5'd0 : i[19:15];
      d.rs2 = (t == "R" || t == "S" || t == "B") ? i[24:20] : 5'd0;
      d.pc  = p;
      d.ill = (t == "X");
      case (t)
         "I": d.imm = s >>> 20;
         "S": d.imm = ((s >>> 25) <<< 5) | int'(i[11:7]);
         "B": d.imm = ((s >>> 31) <<< 12) | (int'(i[7]) << 11) |
                      (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
         "J": d.imm = ((s >>> 31) <<< 20) | (int'(i[19:12]) << 12) |
                      (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
         "U": d.imm = i & 32'hFFFFF000;
         default: d.imm = 32'd0;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67,
                                7'h23, 7'h63, 7'h37, 7'h17,
                                7'h6f, 7'h7f, 7'h73, 7'h0f};
      logic [31:0] r;
      r      = $urandom;
      r[6:0] = ops[$urandom_range(0, 11)];
      return r;
   endfunction

   task automatic drive1(input logic v, input logic [31:0] i,
                         input logic [31:0] p);
      u_in1.in_valid = v;
      u_in1.instr    = i;
      u_in1.pc       = p;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (u_out1.out_valid !== 1'b0)
         $display("FAIL reset_out_valid: got %b want 0", u_out1.out_valid);
      else passed++;
      total++;
      if (u_in1.in_ready !== 1'b1)
         $display("FAIL reset_in_ready: got %b want 1", u_in1.in_ready);
      else passed++;
      total++;
      if (got1() !== '0)
         $display("FAIL reset_data: got %h want 0", got1());
      else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_and();
      dec_t e;
      e = '{7'b0110011, 4'b0111, 5'd10, 5'd10, 5'd15, 32'd0,
            32'h1000, 1'b0};
      @(negedge clk);
      u_out1.out_ready = 1'b1;
      drive1(1'b1, 32'h00F57533, 32'h1000);
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (u_out1.out_valid !== 1'b1)
         $display("FAIL and_valid: got %b want 1", u_out1.out_valid);
      else passed++;
      total++;
      if (got1() !== e)
         $display("FAIL and_fields: got %h want %h", got1(), e);
      else passed++;
      @(negedge clk);
      total++;
      if (u_out1.out_valid !== 1'b0)
         $display("FAIL and_drain: got %b want 0", u_out1.out_valid);
      else passed++;
   endtask

   task automatic test_back_to_back();
      dec_t e_sub, e_sra;
      e_sub = '{7'h33, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0,
                32'h2000, 1'b0};
      e_sra = '{7'h13, 4'b1101, 5'd5, 5'd6, 5'd0, 32'h403,
                32'h2004, 1'b0};
      drive1(1'b1, 32'h403100B3, 32'h2000);
      @(negedge clk);
      drive1(1'b1, 32'h40335293, 32'h2004);
      total++;
      if (got1() !== e_sub || u_out1.out_valid !== 1'b1)
         $display("FAIL b2b_sub: got %h v=%b want %h",
                  got1(), u_out1.out_valid, e_sub);
      else passed++;
      total++;
      if (u_in1.in_ready !== 1'b1)
         $display("FAIL b2b_ready: got %b want 1", u_in1.in_ready);
      else passed++;
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (got1() !== e_sra || u_out1.out_valid !== 1'b1)
         $display("FAIL b2b_srai: got %h v=%b want %h",
                  got1(), u_out1.out_valid, e_sra);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_imm();
      dec_t e_addi, e_beq;
      e_addi = '{7'h13, 4'b0000, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,
                 32'h3000, 1'b0};
      e_beq  = '{7'h63, 4'b0000, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,
                 32'h3004, 1'b0};
      drive1(1'b1, 32'hFFF00093, 32'h3000);
      @(negedge clk);
      drive1(1'b1, 32'hFE000EE3, 32'h3004);
      total++;
      if (got1() !== e_addi)
         $display("FAIL imm_addi: got %h want %h", got1(), e_addi);
      else passed++;
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (got1() !== e_beq)
         $display("FAIL imm_beq: got %h want %h", got1(), e_beq);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] i1, i2, i3;
      dec_t m1, m2, m3;
      i1 = 32'h00A00513; i2 = 32'h40B50533; i3 = 32'h0000A5B7;
      m1 = model(i1, 32'h4000);
      m2 = model(i2, 32'h4004);
      m3 = model(i3, 32'h4008);
      u_out1.out_ready = 1'b0;
      drive1(1'b1, i1, 32'h4000);
      @(negedge clk);
      drive1(1'b1, i2, 32'h4004);
      total++;
      if (got1() !== m1 || u_in1.in_ready !== 1'b1)
         $display("FAIL bp_first: got %h rdy=%b want %h rdy=1",
                  got1(), u_in1.in_ready, m1);
      else passed++;
      @(negedge clk);
      drive1(1'b1, i3, 32'h4008);
      total++;
      if (got1() !== m1 || u_in1.in_ready !== 1'b0)
         $display("FAIL bp_full: got %h rdy=%b want %h rdy=0",
                  got1(), u_in1.in_ready, m1);
      else passed++;
      @(negedge clk);
      total++;
      if (got1() !== m1 || u_in1.in_ready !== 1'b0 ||
          u_out1.out_valid !== 1'b1)
         $display("FAIL bp_hold: got %h rdy=%b want %h rdy=0",
                  got1(), u_in1.in_ready, m1);
      else passed++;
      u_out1.out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (got1() !== m2 || u_in1.in_ready !== 1'b1)
         $display("FAIL bp_second: got %h rdy=%b want %h rdy=1",
                  got1(), u_in1.in_ready, m2);
      else passed++;
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (got1() !== m3 || u_out1.out_valid !== 1'b1)
         $display("FAIL bp_third: got %h want %h", got1(), m3);
      else passed++;
      @(negedge clk);
      total++;
      if (u_out1.out_valid !== 1'b0)
         $display("FAIL bp_drain: got %b want 0", u_out1.out_valid);
      else passed++;
   endtask

   task automatic test_flush();
      u_out1.out_ready = 1'b0;
      drive1(1'b1, 32'h00100093, 32'h5000);
      @(negedge clk);
      drive1(1'b1, 32'h00200113, 32'h5004);
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (u_in1.in_ready !== 1'b0)
         $display("FAIL flush_pre_full: got %b want 0", u_in1.in_ready);
      else passed++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (u_out1.out_valid !== 1'b0 || u_in1.in_ready !== 1'b1)
         $display("FAIL flush_full: v=%b rdy=%b want v=0 rdy=1",
                  u_out1.out_valid, u_in1.in_ready);
      else passed++;
      drive1(1'b1, 32'h00300193, 32'h5008);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (u_out1.out_valid !== 1'b0)
         $display("FAIL flush_accept: v=%b want 0", u_out1.out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if (u_out1.out_valid !== 1'b0)
         $display("FAIL flush_after: v=%b want 0", u_out1.out_valid);
      else passed++;
      u_out1.out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      u_out1.out_ready = 1'b0;
      drive1(1'b1, 32'h12345037, 32'h6000);
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (u_out1.out_valid !== 1'b1)
         $display("FAIL rstmid_pre: v=%b want 1", u_out1.out_valid);
      else passed++;
      #1 reset = 1'b1;
      #1;
      total++;
      if (u_out1.out_valid !== 1'b0 || got1() !== '0 ||
          u_in1.in_ready !== 1'b1)
         $display("FAIL rstmid_async: v=%b data=%h rdy=%b want 0/0/1",
                  u_out1.out_valid, got1(), u_in1.in_ready);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      u_out1.out_ready = 1'b1;
   endtask

   task automatic test_illegal();
      dec_t e;
      e = '{7'h7f, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0, 32'h7000, 1'b1};
      drive1(1'b1, 32'h0000007F, 32'h7000);
      @(negedge clk);
      drive1(1'b0, 32'h0, 32'h0);
      total++;
      if (got1() !== e || u_out1.out_valid !== 1'b1)
         $display("FAIL illegal_pass: got %h v=%b want %h",
                  got1(), u_out1.out_valid, e);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_illegal_drop();
      u_out0.out_ready = 1'b1;
      u_in0.in_valid   = 1'b1;
      u_in0.instr      = 32'h0000007F;
      u_in0.pc         = 32'h8000;
      @(negedge clk);
      u_in0.instr = 32'h00500293;
      u_in0.pc    = 32'h8004;
      total++;
      if (u_out0.out_valid !== 1'b0 || u_in0.in_ready !== 1'b1)
         $display("FAIL illegal_drop: v=%b rdy=%b want v=0 rdy=1",
                  u_out0.out_valid, u_in0.in_ready);
      else passed++;
      @(negedge clk);
      u_in0.in_valid = 1'b0;
      total++;
      if (u_out0.out_valid !== 1'b1 || u_out0.pc_out !== 32'h8004)
         $display("FAIL drop_legal: v=%b pc=%h want v=1 pc=8004",
                  u_out0.out_valid, u_out0.pc_out);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] pcv;
      int          sz;
      logic        acc, pop;
      dec_t        m;
      q.delete();
      pcv = 32'h10000;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         total++;
         if (u_out1.out_valid !== (q.size() > 0))
            $display("FAIL rnd_valid c=%0d: got %b want %b",
                     c, u_out1.out_valid, q.size() > 0);
         else passed++;
         total++;
         if (u_in1.in_ready !== (q.size() < 2))
            $display("FAIL rnd_ready c=%0d: got %b want %b",
                     c, u_in1.in_ready, q.size() < 2);
         else passed++;
         if (q.size() > 0) begin
            total++;
            if (got1() !== q[0])
               $display("FAIL rnd_data c=%0d: got %h want %h",
                        c, got1(), q[0]);
            else passed++;
         end
         if (c >= 590) begin
            drive1(1'b0, 32'h0, 32'h0);
            u_out1.out_ready = 1'b1;
            flush = 1'b0;
         end else begin
            drive1($urandom_range(0, 3) != 0, rand_instr(), pcv);
            u_out1.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
         end
         pcv = pcv + 4;
         sz  = q.size();
         acc = u_in1.in_valid && (sz < 2);
         pop = (sz > 0) && u_out1.out_ready;
         if (flush) begin
            q.delete();
         end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
               m = model(u_in1.instr, u_in1.pc);
               q.push_back(m);
            end
         end
      end
      flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      u_in1.in_valid   = 1'b0;
      u_in1.instr      = 32'h0;
      u_in1.pc         = 32'h0;
      u_out1.out_ready = 1'b0;
      u_in0.in_valid   = 1'b0;
      u_in0.instr      = 32'h0;
      u_in0.pc         = 32'h0;
      u_out0.out_ready = 1'b0;
      test_reset();
      test_and();
      test_back_to_back();
      test_imm();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_illegal();
      test_illegal_drop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
